// File: rtl/run_step_if.sv
// Board-side signal bundle for run_step_controller: buttons, CAR/HALT feedback and sequencer controls.
// RUN_CTRL_BREAKPOINT_EN adds the breakpoint address/valid pair.
interface run_step_if #(
  parameter int CAR_WIDTH = 7
);
  logic                 i_btn_start;
  logic                 i_btn_step;
  logic                 i_mode_step;
  logic [CAR_WIDTH-1:0] i_car_data;
  logic                 i_ctrl_halt;
  logic                 o_ctrl_cpu_start;
  logic                 o_ctrl_step_execution;
  logic                 o_next_instr_stimulus;
  logic [1:0]           o_state;
  logic                 o_halted;
  logic [15:0]          o_instr_count;
`ifdef RUN_CTRL_BREAKPOINT_EN
  logic [CAR_WIDTH-1:0] i_bp_addr;
  logic                 i_bp_valid;
`endif

  modport slave (
`ifdef RUN_CTRL_BREAKPOINT_EN
    input  i_bp_addr, i_bp_valid,
`endif
    input  i_btn_start, i_btn_step, i_mode_step, i_car_data, i_ctrl_halt,
    output o_ctrl_cpu_start, o_ctrl_step_execution, o_next_instr_stimulus,
    output o_state, o_halted, o_instr_count
  );

  modport master (
`ifdef RUN_CTRL_BREAKPOINT_EN
    output i_bp_addr, i_bp_valid,
`endif
    output i_btn_start, i_btn_step, i_mode_step, i_car_data, i_ctrl_halt,
    input  o_ctrl_cpu_start, o_ctrl_step_execution, o_next_instr_stimulus,
    input  o_state, o_halted, o_instr_count
  );
endinterface

// File: rtl/run_step_controller.sv
// Front-panel run controller: debounced start/step buttons, single-step park/release handshake,
// retired-instruction counter. RUN_CTRL_BREAKPOINT_EN adds a sticky CAR breakpoint.
//
// state   | meaning
// IDLE    | CPU stopped, step mode latched from the switch, count cleared
// RUN     | CPU enabled, watching for HALT, stop press or park at WAIT_ADDR
// PARKED  | step-mode CPU waiting at WAIT_ADDR for a step press
// HALTED  | privileged HALT seen, only a start press leaves
module run_step_controller #(
  parameter int                   DEBOUNCE_CYCLES = 16,
  parameter int                   CAR_WIDTH       = 7,
  parameter logic [CAR_WIDTH-1:0] FETCH_ADDR      = 7'h00,
  parameter logic [CAR_WIDTH-1:0] WAIT_ADDR       = 7'h20
) (
  input  logic      i_clk,
  input  logic      i_rst,
  run_step_if.slave bus
);
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PARKED = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  logic [1:0]      btn_raw, btn_meta, btn_sync, btn_level, btn_press;
  logic [DB_W-1:0] db_cnt [2];

  state_t               state_q, state_d;
  logic                 step_flag_q, step_flag_d;
  logic                 stim_q, stim_d;
  logic [15:0]          count_q, count_d;
  logic [CAR_WIDTH-1:0] prev_car_q;
  logic                 cpu_start_q, step_exec_q, halted_q;
  logic                 bp_hit_q, bp_hit_d;
  logic                 car_is_wait, fetch_entry, park_enable;

  assign btn_raw = {bus.i_btn_step, bus.i_btn_start};

  // Bit 0 is start, bit 1 is step; a press fires only when a new high level is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_meta  <= '0;
      btn_sync  <= '0;
      btn_level <= '0;
      btn_press <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      for (int i = 0; i < 2; i++) begin
        btn_press[i] <= 1'b0;
        if (btn_sync[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]    <= '0;
          btn_level[i] <= btn_sync[i];
          btn_press[i] <= btn_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign car_is_wait = (bus.i_car_data == WAIT_ADDR);
  assign fetch_entry = (bus.i_car_data == FETCH_ADDR) && (prev_car_q != FETCH_ADDR);
  assign park_enable = step_flag_q | bp_hit_q;

  always_comb begin
    state_d     = state_q;
    step_flag_d = step_flag_q;
    stim_d      = stim_q;
    count_d     = count_q;
    bp_hit_d    = bp_hit_q;
    case (state_q)
      S_IDLE: begin
        step_flag_d = bus.i_mode_step;
        if (btn_press[0]) state_d = S_RUN;
      end
      S_RUN: begin
        if (fetch_entry && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
`ifdef RUN_CTRL_BREAKPOINT_EN
        if (bus.i_bp_valid && (bus.i_car_data == bus.i_bp_addr)) bp_hit_d = 1'b1;
`endif
        if (bus.i_ctrl_halt) begin
          state_d = S_HALTED;
        end else if (btn_press[0]) begin
          state_d = S_IDLE;
        end else if (stim_q) begin
          if (!car_is_wait) stim_d = 1'b0;
        end else if (park_enable && car_is_wait) begin
          state_d = S_PARKED;
        end
      end
      S_PARKED: begin
        if (bus.i_ctrl_halt) begin
          state_d = S_HALTED;
        end else if (btn_press[0]) begin
          state_d = S_IDLE;
        end else if (btn_press[1]) begin
          state_d = S_RUN;
          stim_d  = 1'b1;
        end
      end
      S_HALTED: begin
        if (btn_press[0]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_d == S_IDLE) || (state_d == S_HALTED)) stim_d = 1'b0;
    if (state_d == S_IDLE) begin
      count_d  = '0;
      bp_hit_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      step_flag_q <= 1'b0;
      stim_q      <= 1'b0;
      count_q     <= '0;
      prev_car_q  <= '0;
      bp_hit_q    <= 1'b0;
      cpu_start_q <= 1'b0;
      step_exec_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_flag_q <= step_flag_d;
      stim_q      <= stim_d;
      count_q     <= count_d;
      prev_car_q  <= bus.i_car_data;
      bp_hit_q    <= bp_hit_d;
      cpu_start_q <= (state_d != S_IDLE);
      step_exec_q <= (state_d != S_IDLE) && (step_flag_d || bp_hit_d);
      halted_q    <= (state_d == S_HALTED);
    end
  end

  assign bus.o_state               = state_q;
  assign bus.o_ctrl_cpu_start      = cpu_start_q;
  assign bus.o_ctrl_step_execution = step_exec_q;
  assign bus.o_next_instr_stimulus = stim_q;
  assign bus.o_halted              = halted_q;
  assign bus.o_instr_count         = count_q;
endmodule

// File: doc/run_step_controller.md
# run_step_controller

Front-panel run controller that drives the control unit's CPU-start, step-execution and next-instruction-stimulus inputs. It watches the control address (CAR) value and the privileged HALT line coming back from the sequencer. It debounces the start/step push-buttons, runs the single-step park/release handshake against the CAR wait address, and counts retired instructions. It sits between the board I/O and the control unit, on the opposite side of the sequencer's start/step/stimulus interface.

## Interface
Reset for this block is synchronous and active-high; clock is `i_clk`, reset is `i_rst`.

Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required to accept a button level (≥1).
- `CAR_WIDTH`, 7: width of control address.
- `FETCH_ADDR`, 7'h00: microprogram fetch address.
- `WAIT_ADDR`, 7'h20: CAR value where a step-mode CPU parks (NOP write-back).

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous active-high reset.
- `i_btn_start`  in  1  raw start/stop button, asynchronous.
- `i_btn_step`  in  1  raw step button, asynchronous.
- `i_mode_step`  in  1  mode switch: 1 = single-step, 0 = free run.
- `i_car_data`  in  CAR_WIDTH  current control address from the sequencer.
- `i_ctrl_halt`  in  1  privileged HALT from the control word.
- `o_ctrl_cpu_start`  out  1  CPU enable to the sequencer.
- `o_ctrl_step_execution`  out  1  step-mode enable to the sequencer.
- `o_next_instr_stimulus`  out  1  release request for a parked CPU.
- `o_state`  out  2  FSM state: 0 IDLE, 1 RUN, 2 PARKED, 3 HALTED.
- `o_halted`  out  1  high in HALTED.
- `o_instr_count`  out  16  instructions fetched since last start; saturating.

## Operation
- **Button front end**
  - Each button passes through a 2-flop synchronizer, then a stability counter.
  - A level is accepted after `DEBOUNCE_CYCLES` consecutive equal synchronized samples.
  - A "press" is a one-cycle internal pulse on an accepted 0→1 change.
- **FSM**
  - IDLE:
    - start press → RUN.
    - Latch `i_mode_step` into the step flag.
    - Clear `o_instr_count`.
  - RUN:
    - `i_ctrl_halt` → HALTED.
    - Otherwise, start press → IDLE.
    - Otherwise, step flag=1 and `i_car_data==WAIT_ADDR` and stimulus low → PARKED.
  - PARKED:
    - halt → HALTED.
    - start press → IDLE.
    - step press → RUN, with `o_next_instr_stimulus` set.
  - HALTED: start press → IDLE; step presses are ignored.
- **Stimulus**
  - `o_next_instr_stimulus` is a level, set on the PARKED→RUN transition.
  - It is held until the first cycle `i_car_data!=WAIT_ADDR`, then cleared.
  - Park detection is suppressed while it is high.
  - It is forced low in IDLE and HALTED.
- **Outputs by state**
  - `o_ctrl_cpu_start` = 1 in RUN, PARKED, HALTED; 0 in IDLE.
  - `o_ctrl_step_execution` = step flag (OR breakpoint hit, see Configuration); 0 in IDLE.
- **Instruction count**
  - Increments when previous-cycle CAR != `FETCH_ADDR`, current CAR == `FETCH_ADDR`, and the FSM is in RUN.
  - Saturates at 16'hFFFF.
- **Priority within one cycle:** reset > halt > start press > step press / park detection.

## Timing
- All outputs are registered. Reset value of every output and internal register is 0; state is IDLE.
- Button latency: a clean input rise at edge N produces the FSM transition at edge N+2+`DEBOUNCE_CYCLES`; outputs change at that edge.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles are never accepted.
- Park detection: CAR equals `WAIT_ADDR` at edge N → `o_state`=PARKED after edge N+1.
- Halt: sampled at edge N → `o_halted`=1 and `o_state`=3 after edge N+1. `o_ctrl_cpu_start` stays 1.
- Count: increments one cycle after the qualifying fetch-address entry.
- Reset mid-handshake: stimulus drops and the FSM returns to IDLE on the same edge. Debounce counters and accepted levels clear to 0, so a button held through reset gives one press after release-free debounce.
- `i_mode_step` changes outside IDLE are ignored.

## Configuration
- `RUN_CTRL_BREAKPOINT_EN`
  - **Defined:**
    - Adds ports `i_bp_addr` (in, CAR_WIDTH) and `i_bp_valid` (in, 1), plus a sticky `bp_hit` flag.
    - `bp_hit` sets in RUN when `i_bp_valid` is high and `i_car_data==i_bp_addr`. It clears on IDLE entry.
    - `o_ctrl_step_execution` = step flag OR `bp_hit`, so a free-running CPU parks at the end of the breakpointed instruction.
  - **Undefined:** ports and flag are absent; step execution equals the latched step flag only.

## Test plan
- **Reset:** `DEBOUNCE_CYCLES`=4; assert `i_rst` 2 cycles → all outputs 0, `o_state`=0.
- **Free-run start:** `i_mode_step`=0, `i_btn_start` high 10 cycles.
  - `o_ctrl_cpu_start`=1 exactly 6 cycles after the rise.
  - CAR model cycles 00→05→00 three times → `o_instr_count`=3.
- **Debounce:** 3-cycle start glitch → no state change.
- **Step handshake:** `i_mode_step`=1, start; CAR=7'h20 → PARKED.
  - Step press → stimulus=1 held while CAR=20 for 3 cycles.
  - CAR=00 → stimulus=0 next cycle; `o_state`=1.
- **Halt priority:** in PARKED, `i_ctrl_halt` coincides with an accepted step press → HALTED, stimulus stays 0.
  - A later start press → IDLE, `o_ctrl_cpu_start`=0.
- **Breakpoint (macro on):** free run, `i_bp_addr`=7'h0B, `i_bp_valid`=1; CAR hits 0B → `o_ctrl_step_execution`=1.
  - Then CAR=20 → PARKED.
